// File: rtl/mdu_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mdu_wb_arbiter_if
// Description : Handshake bundle between the MDU producers (multiplier and
//               divider result streams), the writeback merge stage and the
//               ROB/CDB writeback consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface mdu_wb_arbiter_if #(
  parameter int ROB_WIDTH  = 6,
  parameter int DATA_WIDTH = 32
);
  logic                  mul_valid_i;
  logic                  mul_ready_o;
  logic [ROB_WIDTH-1:0]  mul_reg_addr_i;
  logic [DATA_WIDTH-1:0] mul_result_i;

  logic                  div_valid_i;
  logic                  div_ready_o;
  logic [ROB_WIDTH-1:0]  div_reg_addr_i;
  logic [DATA_WIDTH-1:0] div_result_i;

  logic                  wb_valid_o;
  logic                  wb_ready_i;
  logic [ROB_WIDTH-1:0]  wb_reg_addr_o;
  logic [DATA_WIDTH-1:0] wb_result_o;

  // Seen from the merge stage itself
  modport slave (
    input  mul_valid_i, mul_reg_addr_i, mul_result_i,
    input  div_valid_i, div_reg_addr_i, div_result_i,
    input  wb_ready_i,
    output mul_ready_o, div_ready_o,
    output wb_valid_o, wb_reg_addr_o, wb_result_o
  );

  // Seen from the surrounding producers/consumer
  modport master (
    output mul_valid_i, mul_reg_addr_i, mul_result_i,
    output div_valid_i, div_reg_addr_i, div_result_i,
    output wb_ready_i,
    input  mul_ready_o, div_ready_o,
    input  wb_valid_o, wb_reg_addr_o, wb_result_o
  );
endinterface
`default_nettype wire

// File: rtl/mdu_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mdu_wb_arbiter
// Description : MDU writeback merge. Per-source result FIFOs for multiplier
//               and divider, round-robin arbitration into a single registered
//               writeback port. Producer readies come from registered counts
//               only, so wb_ready_i never reaches a producer combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_wb_arbiter #(
  parameter int ROB_WIDTH  = 6,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  mdu_wb_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ROB_WIDTH + DATA_WIDTH;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // FIFO storage, entries packed as {tag, result}
  logic [ENT_W-1:0]      mul_mem_q [DEPTH];
  logic [ENT_W-1:0]      mul_mem_d [DEPTH];
  logic [ENT_W-1:0]      div_mem_q [DEPTH];
  logic [ENT_W-1:0]      div_mem_d [DEPTH];
  logic [PTR_W-1:0]      mul_rd_ptr_q, mul_rd_ptr_d, mul_wr_ptr_q, mul_wr_ptr_d;
  logic [PTR_W-1:0]      div_rd_ptr_q, div_rd_ptr_d, div_wr_ptr_q, div_wr_ptr_d;
  logic [CNT_W-1:0]      mul_cnt_q, mul_cnt_d, div_cnt_q, div_cnt_d;

  // Output register and arbitration history (0 = mul, 1 = div)
  logic                  wb_valid_q, wb_valid_d;
  logic [ROB_WIDTH-1:0]  wb_reg_addr_q, wb_reg_addr_d;
  logic [DATA_WIDTH-1:0] wb_result_q, wb_result_d;
  logic                  last_grant_q, last_grant_d;

  logic mul_ready, div_ready;
  logic mul_push, div_push;
  logic out_free;
  logic grant_mul, grant_div;

  assign mul_ready = (mul_cnt_q != FULL_CNT);
  assign div_ready = (div_cnt_q != FULL_CNT);

  assign bus.mul_ready_o   = mul_ready;
  assign bus.div_ready_o   = div_ready;
  assign bus.wb_valid_o    = wb_valid_q;
  assign bus.wb_reg_addr_o = wb_reg_addr_q;
  assign bus.wb_result_o   = wb_result_q;

  // Next-state: pushes, round-robin grant into the output register, flush override
  always_comb begin
    mul_mem_d     = mul_mem_q;
    div_mem_d     = div_mem_q;
    mul_rd_ptr_d  = mul_rd_ptr_q;
    mul_wr_ptr_d  = mul_wr_ptr_q;
    div_rd_ptr_d  = div_rd_ptr_q;
    div_wr_ptr_d  = div_wr_ptr_q;
    wb_valid_d    = wb_valid_q;
    wb_reg_addr_d = wb_reg_addr_q;
    wb_result_d   = wb_result_q;
    last_grant_d  = last_grant_q;
    grant_mul     = 1'b0;
    grant_div     = 1'b0;

    mul_push = bus.mul_valid_i && mul_ready && !flush;
    div_push = bus.div_valid_i && div_ready && !flush;
    out_free = !wb_valid_q || bus.wb_ready_i;

    // Mul wins when it is the only candidate or when div was served last
    if (!flush && out_free) begin
      if ((mul_cnt_q != '0) && ((div_cnt_q == '0) || last_grant_q)) begin
        grant_mul = 1'b1;
      end else if (div_cnt_q != '0) begin
        grant_div = 1'b1;
      end
    end

    if (grant_mul) begin
      {wb_reg_addr_d, wb_result_d} = mul_mem_q[mul_rd_ptr_q];
      wb_valid_d   = 1'b1;
      last_grant_d = 1'b0;
      mul_rd_ptr_d = mul_rd_ptr_q + PTR_W'(1);
    end else if (grant_div) begin
      {wb_reg_addr_d, wb_result_d} = div_mem_q[div_rd_ptr_q];
      wb_valid_d   = 1'b1;
      last_grant_d = 1'b1;
      div_rd_ptr_d = div_rd_ptr_q + PTR_W'(1);
    end else if (out_free) begin
      wb_valid_d = 1'b0;
    end

    // Pushed entries become visible to the arbiter only from the next cycle
    if (mul_push) begin
      mul_mem_d[mul_wr_ptr_q] = {bus.mul_reg_addr_i, bus.mul_result_i};
      mul_wr_ptr_d = mul_wr_ptr_q + PTR_W'(1);
    end
    if (div_push) begin
      div_mem_d[div_wr_ptr_q] = {bus.div_reg_addr_i, bus.div_result_i};
      div_wr_ptr_d = div_wr_ptr_q + PTR_W'(1);
    end

    mul_cnt_d = mul_cnt_q + CNT_W'(mul_push) - CNT_W'(grant_mul);
    div_cnt_d = div_cnt_q + CNT_W'(div_push) - CNT_W'(grant_div);

    // Flush empties both FIFOs and the output; mul gets priority afterwards
    if (flush) begin
      mul_rd_ptr_d = '0;
      mul_wr_ptr_d = '0;
      div_rd_ptr_d = '0;
      div_wr_ptr_d = '0;
      mul_cnt_d    = '0;
      div_cnt_d    = '0;
      wb_valid_d   = 1'b0;
      last_grant_d = 1'b1;
    end
  end

  // State registers; reset behaves like flush and also clears payload
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mul_mem_q     <= '{default: '0};
      div_mem_q     <= '{default: '0};
      mul_rd_ptr_q  <= '0;
      mul_wr_ptr_q  <= '0;
      div_rd_ptr_q  <= '0;
      div_wr_ptr_q  <= '0;
      mul_cnt_q     <= '0;
      div_cnt_q     <= '0;
      wb_valid_q    <= 1'b0;
      wb_reg_addr_q <= '0;
      wb_result_q   <= '0;
      last_grant_q  <= 1'b1;
    end else begin
      mul_mem_q     <= mul_mem_d;
      div_mem_q     <= div_mem_d;
      mul_rd_ptr_q  <= mul_rd_ptr_d;
      mul_wr_ptr_q  <= mul_wr_ptr_d;
      div_rd_ptr_q  <= div_rd_ptr_d;
      div_wr_ptr_q  <= div_wr_ptr_d;
      mul_cnt_q     <= mul_cnt_d;
      div_cnt_q     <= div_cnt_d;
      wb_valid_q    <= wb_valid_d;
      wb_reg_addr_q <= wb_reg_addr_d;
      wb_result_q   <= wb_result_d;
      last_grant_q  <= last_grant_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mdu_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_wb_arbiter
// Description : Self-checking bench for mdu_wb_arbiter. A queue-based model
//               of the merge stage is compared against the DUT every cycle,
//               and directed scenarios pin timing and order with literals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_wb_arbiter;
  localparam int ROB_WIDTH  = 6;
  localparam int DATA_WIDTH = 32;
  localparam int DEPTH      = 2;
  localparam int ENT_W      = ROB_WIDTH + DATA_WIDTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  mdu_wb_arbiter_if #(.ROB_WIDTH(ROB_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

  mdu_wb_arbiter #(.ROB_WIDTH(ROB_WIDTH), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Observed writeback transfers (tag and cycle of the handshake)
  int obs_tag[$];
  int obs_cyc[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DATA_WIDTH-1:0] mdat(input int tag);
    return 32'hA500_0000 | 32'(tag);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] ddat(input int tag);
    return 32'h5A00_0000 | 32'(tag);
  endfunction

  // ---------------- behavioural model ----------------
  logic [ENT_W-1:0]      mq[$];
  logic [ENT_W-1:0]      dq[$];
  logic                  m_valid = 1'b0;
  logic [ROB_WIDTH-1:0]  m_tag   = '0;
  logic [DATA_WIDTH-1:0] m_data  = '0;
  logic                  m_last  = 1'b1;
  bit                    started = 1'b0;

  always @(posedge clk) begin
    int  msz, dsz;
    bit  free, pick_div;
    logic [ENT_W-1:0] e;
    cyc++;
    started = 1'b1;
    if (!rst_n) begin
      mq.delete(); dq.delete();
      m_valid = 1'b0; m_tag = '0; m_data = '0; m_last = 1'b1;
    end else if (flush) begin
      mq.delete(); dq.delete();
      m_valid = 1'b0; m_last = 1'b1;
    end else begin
      msz  = mq.size();
      dsz  = dq.size();
      free = !m_valid || bus.wb_ready_i;
      if (free) begin
        if (msz == 0 && dsz == 0) begin
          m_valid = 1'b0;
        end else begin
          pick_div = (dsz != 0) && ((msz == 0) || !m_last);
          if (pick_div) e = dq.pop_front();
          else          e = mq.pop_front();
          {m_tag, m_data} = e;
          m_valid = 1'b1;
          m_last  = pick_div;
        end
      end
      if (bus.mul_valid_i && msz != DEPTH) mq.push_back({bus.mul_reg_addr_i, bus.mul_result_i});
      if (bus.div_valid_i && dsz != DEPTH) dq.push_back({bus.div_reg_addr_i, bus.div_result_i});
    end
  end

  // Compare DUT against model mid-cycle, and log completed handshakes
  always @(negedge clk) begin
    if (started) begin
      chk("wb_valid",    64'(bus.wb_valid_o),    64'(m_valid));
      chk("wb_reg_addr", 64'(bus.wb_reg_addr_o), 64'(m_tag));
      chk("wb_result",   64'(bus.wb_result_o),   64'(m_data));
      chk("mul_ready",   64'(bus.mul_ready_o),   64'(mq.size() != DEPTH));
      chk("div_ready",   64'(bus.div_ready_o),   64'(dq.size() != DEPTH));
      if (bus.wb_valid_o && bus.wb_ready_i && rst_n && !flush) begin
        obs_tag.push_back(int'(bus.wb_reg_addr_o));
        obs_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.mul_valid_i = 1'b0; bus.mul_reg_addr_i = '0; bus.mul_result_i = '0;
    bus.div_valid_i = 1'b0; bus.div_reg_addr_i = '0; bus.div_result_i = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0;
    idle_inputs();
    bus.wb_ready_i = 1'b1;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic drive_mul(input int tag);
    bus.mul_valid_i = 1'b1; bus.mul_reg_addr_i = 6'(tag); bus.mul_result_i = mdat(tag);
  endtask

  task automatic drive_div(input int tag);
    bus.div_valid_i = 1'b1; bus.div_reg_addr_i = 6'(tag); bus.div_result_i = ddat(tag);
  endtask

  // Producers that hold each result until it is accepted; consumer stalls for
  // the first 'stall' cycles. Fixed 40-cycle window bounds the run.
  task automatic stream(input int nm, input int nd, input int mbase, input int dbase,
                        input int stall, input bit bp_check);
    int  mi = 0, di = 0;
    bit  macc, dacc;
    for (int c = 0; c < 40; c++) begin
      if (bp_check && c == 3) begin
        chk("bp_mul_ready_low", 64'(bus.mul_ready_o),   64'd0);
        chk("bp_hold_valid",    64'(bus.wb_valid_o),    64'd1);
        chk("bp_hold_tag",      64'(bus.wb_reg_addr_o), 64'(mbase));
      end
      bus.wb_ready_i = (c >= stall);
      idle_inputs();
      if (mi < nm) drive_mul(mbase + mi);
      if (di < nd) drive_div(dbase + di);
      macc = bus.mul_valid_i && bus.mul_ready_o;
      dacc = bus.div_valid_i && bus.div_ready_o;
      step();
      if (macc) mi++;
      if (dacc) di++;
    end
    idle_inputs();
    chk("stream_mul_all_accepted", 64'(mi), 64'(nm));
    chk("stream_div_all_accepted", 64'(di), 64'(nd));
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    idle_inputs();
    bus.wb_ready_i = 1'b1;
    do_reset();

    // Reset values
    chk("rst_wb_valid", 64'(bus.wb_valid_o),    64'd0);
    chk("rst_wb_tag",   64'(bus.wb_reg_addr_o), 64'd0);
    chk("rst_wb_data",  64'(bus.wb_result_o),   64'd0);
    chk("rst_mul_rdy",  64'(bus.mul_ready_o),   64'd1);
    chk("rst_div_rdy",  64'(bus.div_ready_o),   64'd1);

    // Single multiplier result: two-cycle latency, one-cycle output pulse
    bus.mul_valid_i = 1'b1; bus.mul_reg_addr_i = 6'd5; bus.mul_result_i = 32'h1234;
    step();
    idle_inputs();
    chk("single_lat1_valid", 64'(bus.wb_valid_o), 64'd0);
    step();
    chk("single_valid", 64'(bus.wb_valid_o),    64'd1);
    chk("single_tag",   64'(bus.wb_reg_addr_o), 64'd5);
    chk("single_data",  64'(bus.wb_result_o),   64'h1234);
    step();
    chk("single_after", 64'(bus.wb_valid_o), 64'd0);

    // Simultaneous sources after reset: mul first, then div
    do_reset();
    drive_mul(1); drive_div(2);
    step();
    idle_inputs();
    chk("simul_lat1_valid", 64'(bus.wb_valid_o), 64'd0);
    step();
    chk("simul_first_valid", 64'(bus.wb_valid_o),    64'd1);
    chk("simul_first_tag",   64'(bus.wb_reg_addr_o), 64'd1);
    step();
    chk("simul_second_valid", 64'(bus.wb_valid_o),    64'd1);
    chk("simul_second_tag",   64'(bus.wb_reg_addr_o), 64'd2);
    chk("simul_second_data",  64'(bus.wb_result_o),   64'(ddat(2)));
    step();
    chk("simul_done", 64'(bus.wb_valid_o), 64'd0);

    // Continuous contention: strict alternation, no bubbles
    do_reset();
    obs_tag.delete(); obs_cyc.delete();
    stream(8, 8, 16, 32, 0, 1'b0);
    chk("cont_count", 64'(obs_tag.size()), 64'd16);
    if (obs_tag.size() == 16) begin
      for (int k = 0; k < 16; k++)
        chk("cont_order", 64'(obs_tag[k]), 64'((k % 2 == 0) ? 16 + k / 2 : 32 + k / 2));
      chk("cont_no_bubbles", 64'(obs_cyc[15] - obs_cyc[0]), 64'd15);
    end

    // Backpressure: A,B,C accepted, D waits, order preserved
    do_reset();
    obs_tag.delete(); obs_cyc.delete();
    stream(4, 0, 8, 0, 8, 1'b1);
    chk("bp_count", 64'(obs_tag.size()), 64'd4);
    if (obs_tag.size() == 4) begin
      for (int k = 0; k < 4; k++)
        chk("bp_order", 64'(obs_tag[k]), 64'(8 + k));
    end

    // Flush mid-stream with both FIFOs occupied and output valid
    do_reset();
    bus.wb_ready_i = 1'b0;
    drive_mul(40); drive_div(50);
    step();
    drive_mul(41); drive_div(51);
    step();
    idle_inputs();
    step();
    chk("flush_pre_valid", 64'(bus.wb_valid_o), 64'd1);
    flush = 1'b1;
    drive_mul(60);
    obs_tag.delete(); obs_cyc.delete();
    step();
    flush = 1'b0;
    idle_inputs();
    chk("flush_valid_low", 64'(bus.wb_valid_o),  64'd0);
    chk("flush_mul_rdy",   64'(bus.mul_ready_o), 64'd1);
    chk("flush_div_rdy",   64'(bus.div_ready_o), 64'd1);
    bus.wb_ready_i = 1'b1;
    drive_mul(61); drive_div(62);
    step();
    idle_inputs();
    repeat (5) step();
    chk("flush_post_count", 64'(obs_tag.size()), 64'd2);
    if (obs_tag.size() == 2) begin
      chk("flush_post_first",  64'(obs_tag[0]), 64'd61);
      chk("flush_post_second", 64'(obs_tag[1]), 64'd62);
    end

    // Reset while the output is stalled: nothing stale survives
    bus.wb_ready_i = 1'b0;
    drive_mul(20); drive_div(22);
    step();
    drive_mul(21);
    bus.div_valid_i = 1'b0;
    step();
    idle_inputs();
    step(); step();
    chk("rmid_pre_valid", 64'(bus.wb_valid_o), 64'd1);
    rst_n = 1'b0;
    step();
    chk("rmid_wb_valid", 64'(bus.wb_valid_o),    64'd0);
    chk("rmid_wb_tag",   64'(bus.wb_reg_addr_o), 64'd0);
    chk("rmid_wb_data",  64'(bus.wb_result_o),   64'd0);
    chk("rmid_mul_rdy",  64'(bus.mul_ready_o),   64'd1);
    chk("rmid_div_rdy",  64'(bus.div_ready_o),   64'd1);
    rst_n = 1'b1;
    bus.wb_ready_i = 1'b1;
    obs_tag.delete(); obs_cyc.delete();
    repeat (6) step();
    chk("rmid_no_stale", 64'(obs_tag.size()), 64'd0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
